// File: rtl/nios_sw_debounce.sv
// Per-bit switch debouncer: 2-flop sync, shared tick prescaler, per-bit stability count.
// Latency SYNC_STAGES + STABLE_TICKS ticks; free-running input, no backpressure.
module nios_sw_debounce #(
  parameter int WIDTH        = 18,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_async,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [PW-1:0]                     r_pcnt;
  logic [WIDTH-1:0][CW-1:0]          r_cnt;
  logic [WIDTH-1:0]                  r_clean;
  logic [WIDTH-1:0]                  r_rise;
  logic [WIDTH-1:0]                  r_fall;
  logic                              r_changed;

  logic [WIDTH-1:0]                  w_sw_s;
  logic                              w_tick;
  logic [WIDTH-1:0][CW-1:0]          w_cnt_nxt;
  logic [WIDTH-1:0]                  w_clean_nxt;
  logic [WIDTH-1:0]                  w_rise;
  logic [WIDTH-1:0]                  w_fall;

  assign w_sw_s = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_pcnt == PW'(TICK_DIV - 1));

  // Returning to the accepted level discards any partial count.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_sw_s[i] == r_clean[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_tick && (r_cnt[i] == CW'(STABLE_TICKS - 1))) begin
        w_clean_nxt[i] = w_sw_s[i];
        w_cnt_nxt[i]   = '0;
      end else if (w_tick) begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  assign w_rise = w_clean_nxt & ~r_clean;
  assign w_fall = ~w_clean_nxt & r_clean;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_pcnt    <= '0;
      r_cnt     <= '0;
      r_clean   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], sw_async};
      r_pcnt    <= w_tick ? '0 : r_pcnt + PW'(1);
      r_cnt     <= w_cnt_nxt;
      r_clean   <= w_clean_nxt;
      r_rise    <= w_rise;
      r_fall    <= w_fall;
      r_changed <= |{w_rise, w_fall};
    end
  end

  assign sw_clean   = r_clean;
  assign sw_rise    = r_rise;
  assign sw_fall    = r_fall;
  assign sw_changed = r_changed;

endmodule

// File: tb/tb_nios_sw_debounce.sv
// Directed checks of nios_sw_debounce at TICK_DIV=4/STABLE_TICKS=3 and TICK_DIV=1/STABLE_TICKS=1.
module tb_nios_sw_debounce;

  logic        clk;
  logic        reset;
  logic [17:0] sw_async;
  logic [17:0] sw_clean, sw_rise, sw_fall;
  logic        sw_changed;
  logic [17:0] f_sw;
  logic [17:0] f_clean, f_rise, f_fall;
  logic        f_changed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  nios_sw_debounce #(.WIDTH(18), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk(clk), .reset(reset), .sw_async(sw_async),
    .sw_clean(sw_clean), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
  );

  nios_sw_debounce #(.WIDTH(18), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(1)) u_fast (
    .clk(clk), .reset(reset), .sw_async(f_sw),
    .sw_clean(f_clean), .sw_rise(f_rise), .sw_fall(f_fall), .sw_changed(f_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first, nrise, nfall, nchg, t0, ticks, rcyc, fcyc;
    logic [17:0] rval, fval;

    // 1: all switches high through reset
    reset    = 1'b1;
    sw_async = 18'h3FFFF;
    f_sw     = 18'h0;
    repeat (3) step();
    chk("t1_rst_clean", sw_clean, 18'h0);
    chk("t1_rst_rise", sw_rise, 18'h0);
    chk("t1_rst_fall", sw_fall, 18'h0);
    chk("t1_rst_changed", sw_changed, 1'b0);
    reset = 1'b0;
    cyc = 0; first = -1; nrise = 0; nchg = 0; rval = '0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (first < 0 && sw_clean == 18'h3FFFF) first = cyc;
      if (sw_rise != 0) begin nrise++; rval = sw_rise; end
      if (sw_changed) nchg++;
    end
    chk("t1_accept_cycle", first, 12);
    chk("t1_rise_count", nrise, 1);
    chk("t1_rise_val", rval, 18'h3FFFF);
    chk("t1_changed_count", nchg, 1);

    sw_async = 18'h0;
    repeat (30) step();
    chk("t1_all_low", sw_clean, 18'h0);

    // 2: bit0 rises and holds
    sw_async[0] = 1'b1;
    t0 = cyc; first = -1; nrise = 0; nfall = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (first < 0 && sw_clean[0]) first = cyc - t0;
      if (sw_rise[0]) nrise++;
      if (sw_fall != 0) nfall++;
    end
    chk("t2_latency_ok", (first >= 11 && first <= 14), 1);
    chk("t2_rise_count", nrise, 1);
    chk("t2_fall_count", nfall, 0);
    chk("t2_clean", sw_clean, 18'h00001);

    // 3: bit5 bounces, never stable for three ticks
    nrise = 0; nchg = 0;
    for (int r = 0; r < 5; r++) begin
      sw_async[5] = 1'b1;
      for (int n = 0; n < 6; n++) begin
        step();
        if (sw_clean[5]) nrise++;
        if ((sw_rise | sw_fall) != 0 || sw_changed) nchg++;
      end
      sw_async[5] = 1'b0;
      for (int n = 0; n < 6; n++) begin
        step();
        if (sw_clean[5]) nrise++;
        if ((sw_rise | sw_fall) != 0 || sw_changed) nchg++;
      end
    end
    chk("t3_clean5_high_cycles", nrise, 0);
    chk("t3_pulse_cycles", nchg, 0);

    // 4: bit3 up and bit17 down on the same edge
    sw_async[17] = 1'b1;
    repeat (30) step();
    chk("t4_setup", sw_clean, 18'h20001);
    sw_async[3]  = 1'b1;
    sw_async[17] = 1'b0;
    rcyc = -1; fcyc = -2; rval = '0; fval = '0; nchg = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (sw_rise != 0) begin rcyc = cyc; rval = sw_rise; end
      if (sw_fall != 0) begin fcyc = cyc; fval = sw_fall; end
      if (sw_changed) nchg++;
    end
    chk("t4_rise_val", rval, 18'h00008);
    chk("t4_fall_val", fval, 18'h20000);
    chk("t4_same_cycle", rcyc, fcyc);
    chk("t4_changed_count", nchg, 1);
    chk("t4_clean", sw_clean, 18'h00009);

    // 5: reset while bit9 is two ticks into its count
    sw_async[9] = 1'b1;
    t0 = cyc; ticks = 0;
    while (ticks < 2) begin
      step();
      if ((cyc - t0) >= 3 && (cyc % 4) == 0) ticks++;
    end
    chk("t5_not_yet", sw_clean[9], 1'b0);
    reset = 1'b1;
    step();
    chk("t5_rst_clean", sw_clean, 18'h0);
    chk("t5_rst_rise", sw_rise, 18'h0);
    chk("t5_rst_fall", sw_fall, 18'h0);
    chk("t5_rst_changed", sw_changed, 1'b0);
    reset = 1'b0;
    cyc = 0; first = -1; nrise = 0; rval = '0;
    for (int n = 0; n < 16; n++) begin
      step();
      if (first < 0 && sw_clean != 0) first = cyc;
      if (sw_rise != 0) begin nrise++; rval = sw_rise; end
    end
    chk("t5_reaccept_cycle", first, 12);
    chk("t5_rise_count", nrise, 1);
    chk("t5_rise_val", rval, 18'h00209);

    // 6: TICK_DIV=1, STABLE_TICKS=1 instance
    f_sw = 18'h00004;
    step(); step();
    chk("t6_edge2_clean", f_clean, 18'h0);
    step();
    chk("t6_edge3_clean", f_clean, 18'h00004);
    chk("t6_edge3_rise", f_rise, 18'h00004);
    chk("t6_edge3_changed", f_changed, 1'b1);
    step();
    chk("t6_edge4_rise", f_rise, 18'h0);
    chk("t6_edge4_changed", f_changed, 1'b0);
    f_sw = 18'h0;
    step(); step();
    chk("t6_fall_edge2_clean", f_clean, 18'h00004);
    step();
    chk("t6_fall_edge3_clean", f_clean, 18'h0);
    chk("t6_fall_edge3_fall", f_fall, 18'h00004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
